// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 256x8 data memory, stack pointer, and the registered
// writeback / return-target bundle presented to the W stage.
module mem_wb_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       D_mem_wenM,
  input  logic       D_mem_renM,
  input  logic       sp_mux_sM,
  input  logic       RET_flushM,
  input  logic       RET_enM,
  input  logic [1:0] mux9sM,
  input  logic [1:0] dest_addrM,
  input  logic [1:0] reg_file_wenM,
  input  logic [2:0] mux8sM,
  input  logic [2:0] mux10sM,
  input  logic [7:0] ALU_resultM,
  input  logic [7:0] sub_outM,
  input  logic [7:0] instrM,
  input  logic [7:0] pcM,
  input  logic [7:0] Imm_M,
  input  logic [7:0] data_out1M,
  input  logic [7:0] data_out2M,
  output logic [7:0] wb_dataW,
  output logic [1:0] dest_addrW,
  output logic [1:0] reg_file_wenW,
  output logic [7:0] instrW,
  output logic [7:0] ret_pcW,
  output logic       ret_validW,
  output logic       ret_flushW,
  output logic [7:0] sp_out
);

  logic [7:0] mem [256];
  logic [7:0] sp;
  logic [7:0] sp_inc;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] wb_data;

  assign sp_inc = sp + 8'd1;
  assign sp_out = sp;

  always_comb begin
    addr = 8'h00;
    case (mux8sM)
      3'd0:    addr = ALU_resultM;
      3'd1:    addr = data_out1M;
      3'd2:    addr = data_out2M;
      3'd3:    addr = sp;
      3'd4:    addr = sp_inc;
      3'd5:    addr = Imm_M;
      3'd6:    addr = 8'h00;
      default: addr = 8'h01;
    endcase
  end

  always_comb begin
    wdata = 8'h00;
    case (mux9sM)
      2'd0:    wdata = data_out1M;
      2'd1:    wdata = data_out2M;
      2'd2:    wdata = pcM;
      default: wdata = ALU_resultM;
    endcase
  end

  // Combinational read sees the pre-edge contents, so read-before-write falls out naturally.
  assign rdata = D_mem_renM ? mem[addr] : 8'h00;

  always_comb begin
    wb_data = 8'h00;
    case (mux10sM)
      3'd0:    wb_data = ALU_resultM;
      3'd1:    wb_data = rdata;
      3'd2:    wb_data = Imm_M;
      3'd3:    wb_data = data_out2M;
      3'd4:    wb_data = pcM;
      default: wb_data = 8'h00;
    endcase
  end

  // Memory is not reset, but writes are gated so a reset pulse drops the in-flight store.
  always_ff @(posedge clk) begin
    if (rst_n && D_mem_wenM)
      mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp            <= 8'hFF;
      wb_dataW      <= 8'h00;
      dest_addrW    <= 2'b00;
      reg_file_wenW <= 2'b00;
      instrW        <= 8'h00;
      ret_pcW       <= 8'h00;
      ret_validW    <= 1'b0;
      ret_flushW    <= 1'b0;
    end else begin
      if (sp_mux_sM && D_mem_wenM)
        sp <= sub_outM;
      else if (sp_mux_sM && D_mem_renM)
        sp <= sp_inc;
      wb_dataW      <= wb_data;
      dest_addrW    <= dest_addrM;
      reg_file_wenW <= reg_file_wenM;
      instrW        <= instrM;
      if (RET_enM)
        ret_pcW <= rdata;
      ret_validW    <= RET_enM & D_mem_renM;
      ret_flushW    <= RET_flushM;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected W-stage values from a
// behavioural model; a monitor pops and compares one cycle later.
module tb_mem_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       D_mem_wenM = 0, D_mem_renM = 0, sp_mux_sM = 0, RET_flushM = 0, RET_enM = 0;
  logic [1:0] mux9sM = 0, dest_addrM = 0, reg_file_wenM = 0;
  logic [2:0] mux8sM = 0, mux10sM = 0;
  logic [7:0] ALU_resultM = 0, sub_outM = 0, instrM = 0, pcM = 0, Imm_M = 0;
  logic [7:0] data_out1M = 0, data_out2M = 0;
  logic [7:0] wb_dataW, instrW, ret_pcW, sp_out;
  logic [1:0] dest_addrW, reg_file_wenW;
  logic       ret_validW, ret_flushW;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .D_mem_wenM(D_mem_wenM), .D_mem_renM(D_mem_renM), .sp_mux_sM(sp_mux_sM),
    .RET_flushM(RET_flushM), .RET_enM(RET_enM),
    .mux9sM(mux9sM), .dest_addrM(dest_addrM), .reg_file_wenM(reg_file_wenM),
    .mux8sM(mux8sM), .mux10sM(mux10sM),
    .ALU_resultM(ALU_resultM), .sub_outM(sub_outM), .instrM(instrM), .pcM(pcM),
    .Imm_M(Imm_M), .data_out1M(data_out1M), .data_out2M(data_out2M),
    .wb_dataW(wb_dataW), .dest_addrW(dest_addrW), .reg_file_wenW(reg_file_wenW),
    .instrW(instrW), .ret_pcW(ret_pcW), .ret_validW(ret_validW),
    .ret_flushW(ret_flushW), .sp_out(sp_out)
  );

  typedef struct packed {
    logic       wen, ren, spm, rflush, reten;
    logic [1:0] m9, dest, rfw;
    logic [2:0] m8, m10;
    logic [7:0] alu, sub, instr, pc, imm, d1, d2;
  } stim_t;

  typedef struct packed {
    logic [7:0] wb, instr, ret_pc, sp;
    logic [1:0] dest, rfw;
    logic       ret_v, ret_f;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_mem [256];
  logic [7:0] m_sp;
  logic [7:0] m_ret_pc;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("wb_dataW", wb_dataW, e.wb);
      chk("dest_addrW", {6'd0, dest_addrW}, {6'd0, e.dest});
      chk("reg_file_wenW", {6'd0, reg_file_wenW}, {6'd0, e.rfw});
      chk("instrW", instrW, e.instr);
      chk("ret_pcW", ret_pcW, e.ret_pc);
      chk("ret_validW", {7'd0, ret_validW}, {7'd0, e.ret_v});
      chk("ret_flushW", {7'd0, ret_flushW}, {7'd0, e.ret_f});
      chk("sp_out", sp_out, e.sp);
    end
  end

  task automatic apply(input stim_t s);
    D_mem_wenM = s.wen;  D_mem_renM = s.ren;  sp_mux_sM = s.spm;
    RET_flushM = s.rflush; RET_enM = s.reten;
    mux9sM = s.m9; dest_addrM = s.dest; reg_file_wenM = s.rfw;
    mux8sM = s.m8; mux10sM = s.m10;
    ALU_resultM = s.alu; sub_outM = s.sub; instrM = s.instr; pcM = s.pc;
    Imm_M = s.imm; data_out1M = s.d1; data_out2M = s.d2;
  endtask

  // Drive one cycle and record what the W stage must show after the next edge.
  task automatic drive(input stim_t s);
    logic [7:0] a_sel [8];
    logic [7:0] w_sel [4];
    logic [7:0] b_sel [8];
    logic [7:0] a, rd;
    exp_t e;
    @(negedge clk);
    apply(s);
    a_sel[0] = s.alu; a_sel[1] = s.d1; a_sel[2] = s.d2; a_sel[3] = m_sp;
    a_sel[4] = 8'((int'(m_sp) + 1) % 256); a_sel[5] = s.imm; a_sel[6] = 8'h00; a_sel[7] = 8'h01;
    a = a_sel[s.m8];
    w_sel[0] = s.d1; w_sel[1] = s.d2; w_sel[2] = s.pc; w_sel[3] = s.alu;
    rd = s.ren ? m_mem[a] : 8'h00;
    b_sel[0] = s.alu; b_sel[1] = rd; b_sel[2] = s.imm; b_sel[3] = s.d2; b_sel[4] = s.pc;
    b_sel[5] = 8'h00; b_sel[6] = 8'h00; b_sel[7] = 8'h00;
    if (s.reten) m_ret_pc = rd;
    if (s.spm && s.wen)      m_sp = s.sub;
    else if (s.spm && s.ren) m_sp = 8'((int'(m_sp) + 1) % 256);
    if (s.wen) m_mem[a] = w_sel[s.m9];
    e.wb = b_sel[s.m10]; e.dest = s.dest; e.rfw = s.rfw; e.instr = s.instr;
    e.ret_pc = m_ret_pc; e.ret_v = s.reten & s.ren; e.ret_f = s.rflush; e.sp = m_sp;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".wb_dataW"}, wb_dataW, 8'h00);
    chk({tag, ".dest_addrW"}, {6'd0, dest_addrW}, 8'h00);
    chk({tag, ".reg_file_wenW"}, {6'd0, reg_file_wenW}, 8'h00);
    chk({tag, ".instrW"}, instrW, 8'h00);
    chk({tag, ".ret_pcW"}, ret_pcW, 8'h00);
    chk({tag, ".ret_validW"}, {7'd0, ret_validW}, 8'h00);
    chk({tag, ".ret_flushW"}, {7'd0, ret_flushW}, 8'h00);
    chk({tag, ".sp_out"}, sp_out, 8'hFF);
  endtask

  initial begin
    stim_t s;
    s = '0;
    apply(s);
    m_sp = 8'hFF;
    m_ret_pc = 8'h00;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill memory so every later read has a known value.
    for (int i = 0; i < 256; i++) begin
      s = '0; s.wen = 1; s.m8 = 3'd5; s.imm = 8'(i); s.m9 = 2'd3; s.alu = 8'(i) ^ 8'h5A;
      drive(s);
    end

    // Store then load through the immediate address.
    s = '0; s.wen = 1; s.m8 = 3'd5; s.imm = 8'h20; s.m9 = 2'd0; s.d1 = 8'hA5; drive(s);
    s = '0; s.ren = 1; s.m8 = 3'd5; s.imm = 8'h20; s.m10 = 3'd1; drive(s);

    // Push 3C at FF, pop it back.
    s = '0; s.wen = 1; s.spm = 1; s.m8 = 3'd3; s.sub = 8'hFE; s.m9 = 2'd1; s.d2 = 8'h3C; drive(s);
    s = '0; s.ren = 1; s.spm = 1; s.m8 = 3'd4; s.m10 = 3'd1; drive(s);

    // RET: push 42, pop it as a return target with flush, then idle.
    s = '0; s.wen = 1; s.spm = 1; s.m8 = 3'd3; s.sub = 8'hFE; s.m9 = 2'd1; s.d2 = 8'h42; drive(s);
    s = '0; s.ren = 1; s.spm = 1; s.m8 = 3'd4; s.reten = 1; s.rflush = 1; drive(s);
    s = '0; drive(s);
    // Back-to-back RET pulses.
    s = '0; s.ren = 1; s.reten = 1; s.rflush = 1; s.m8 = 3'd6; drive(s);
    s = '0; s.ren = 1; s.reten = 1; s.rflush = 1; s.m8 = 3'd7; drive(s);

    // SP wrap: pop at FF reads address 00 and wraps SP to 00.
    s = '0; s.ren = 1; s.spm = 1; s.m8 = 3'd4; s.m10 = 3'd1; drive(s);
    // Push with sub_out FF from SP 00, and push priority over pop.
    s = '0; s.wen = 1; s.ren = 1; s.spm = 1; s.m8 = 3'd3; s.sub = 8'hFF; s.m9 = 2'd2; s.pc = 8'h77; drive(s);

    // Simultaneous read/write returns the old data.
    s = '0; s.wen = 1; s.m8 = 3'd5; s.imm = 8'h10; s.m9 = 2'd0; s.d1 = 8'h11; drive(s);
    s = '0; s.wen = 1; s.ren = 1; s.m8 = 3'd5; s.imm = 8'h10; s.m9 = 2'd0; s.d1 = 8'h22; s.m10 = 3'd1; drive(s);
    s = '0; s.ren = 1; s.m8 = 3'd5; s.imm = 8'h10; s.m10 = 3'd1; drive(s);

    repeat (300) begin
      s = stim_t'({$urandom, $urandom, $urandom, $urandom});
      drive(s);
    end

    // Reset mid-operation: the pending store to 30 must be dropped.
    @(negedge clk);
    s = '0; s.wen = 1; s.m8 = 3'd5; s.imm = 8'h30; s.m9 = 2'd0; s.d1 = ~m_mem[8'h30];
    apply(s);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    m_sp = 8'hFF;
    m_ret_pc = 8'h00;
    #1;
    check_reset_outputs("async_reset");
    s = '0;
    apply(s);
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    s = '0; s.ren = 1; s.m8 = 3'd5; s.imm = 8'h30; s.m10 = 3'd1; drive(s);

    repeat (100) begin
      s = stim_t'({$urandom, $urandom, $urandom, $urandom});
      drive(s);
    end

    s = '0;
    @(negedge clk);
    apply(s);
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
